// File: rtl/moore_pd_pkg.sv
// moore_pd_pkg: shared defaults and the combinational prefix search used as the
// next-state function of moore_pattern_detector.
package moore_pd_pkg;
  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int MAX_W = 16;
  localparam logic [MAX_W-1:0] PAT_RST_DEF = 16'b1011;
  // Largest j <= min(k+1, pat_w) whose last j bits of {history,in} equal the top j pattern bits
  function automatic logic [4:0] prefix_len(input logic [MAX_W-1:0] history, input logic in,
                                            input logic [MAX_W-1:0] pattern, input int k,
                                            input int pat_w);
    logic [MAX_W:0] h;
    logic hit;
    int lim;
    prefix_len = '0;
    h = {history, in};
    lim = (k + 1 > pat_w) ? pat_w : k + 1;
    for (int j = 1; j <= MAX_W; j++) begin
      hit = j <= lim;
      for (int i = 0; i < MAX_W; i++)
        if (i < j && h[5'(i)] != pattern[4'(pat_w - j + i)]) hit = 1'b0;
      if (hit) prefix_len = 5'(j);
    end
  endfunction
endpackage

// File: rtl/moore_pd_counter.sv
// moore_pd_counter: saturating match counter; a clear coinciding with an increment yields 1.
module moore_pd_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= CNT_W'(inc);
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/moore_pattern_detector.sv
// moore_pattern_detector: programmable Moore serial pattern detector with overlap control.
// Define MOORE_PD_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module moore_pattern_detector
  import moore_pd_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter int               CNT_W   = CNT_W_DEF,
  localparam int              ST_W    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             overlap,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cnt_clear,
  output logic             match,
  output logic [ST_W-1:0]  state_o,
  output logic [CNT_W-1:0] match_cnt
);
  localparam logic [ST_W-1:0] S_MATCH = ST_W'(PAT_W);
  logic [PAT_W-1:0] pat, hist, hist_nxt;
  logic [ST_W-1:0]  state, state_nxt;
  logic             fresh;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= '0;
      hist  <= '0;
      pat   <= PAT_RST;
      match <= 1'b0;
    end else begin
      state <= state_nxt;
      hist  <= hist_nxt;
      match <= state_nxt == S_MATCH;
      if (load) pat <= pattern_i;
    end
  // Non-overlapping mode restarts the search from scratch once a match has been reported
  always_comb begin
    fresh = state == S_MATCH && !overlap;
    state_nxt = load ? '0 : !in_valid ? state : fresh ? ST_W'(in == pat[PAT_W-1]) :
                ST_W'(prefix_len(MAX_W'(hist), in, MAX_W'(pat), int'(state), PAT_W));
    hist_nxt = load ? '0 : !in_valid ? hist : fresh ? PAT_W'(in) : {hist[PAT_W-2:0], in};
  end
  assign state_o = state;
`ifdef MOORE_PD_MATCH_CNT_EN
  logic inc;
  assign inc = state_nxt == S_MATCH && !(state == S_MATCH && !in_valid);
  moore_pd_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (inc),
    .clr    (cnt_clear),
    .cnt    (match_cnt)
  );
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_moore_pattern_detector.sv
// tb_moore_pattern_detector: directed stimulus with queued expectations checked by a monitor.
module tb_moore_pattern_detector;
`ifdef MOORE_PD_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct {
    int         id;
    logic [2:0] st;
    logic       m;
    logic [1:0] c;
  } exp_t;
  logic clk = 0, reset_n = 1, load = 0, overlap = 0, in_valid = 0, in_b = 0, cnt_clear = 0;
  logic [3:0] pattern_i = '0;
  logic [2:0] state_o;
  logic       match;
  logic [1:0] match_cnt;
  exp_t q[$];
  int errors = 0, checks = 0, n_step = 0;
  always #5 clk = ~clk;
  moore_pattern_detector #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .pattern_i(pattern_i),
    .overlap  (overlap),
    .in_valid (in_valid),
    .in       (in_b),
    .cnt_clear(cnt_clear),
    .match    (match),
    .state_o  (state_o),
    .match_cnt(match_cnt)
  );
  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask
  task automatic step(input logic ld, input logic [3:0] pt, input logic ov, input logic v,
                      input logic b, input logic cl, input logic [2:0] st, input logic m,
                      input logic [1:0] c);
    exp_t e;
    @(negedge clk);
    load = ld; pattern_i = pt; overlap = ov; in_valid = v; in_b = b; cnt_clear = cl;
    e.id = n_step; e.st = st; e.m = m; e.c = CNT_EN ? c : 2'd0;
    q.push_back(e);
    n_step++;
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("state", e.id, 32'(state_o), 32'(e.st));
      chk("match", e.id, 32'(match), 32'(e.m));
      chk("cnt", e.id, 32'(match_cnt), 32'(e.c));
    end
  end
  initial begin
    #1 reset_n = 0;
    #6;
    chk("rst_state", -1, 32'(state_o), 0);
    chk("rst_match", -1, 32'(match), 0);
    chk("rst_cnt", -1, 32'(match_cnt), 0);
    @(negedge clk) reset_n = 1;
    // overlapping 1011 on 1,0,1,1,0,1,1
    step(0, 4'h0, 1, 1, 1, 0, 1, 0, 0);
    step(0, 4'h0, 1, 1, 0, 0, 2, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 3, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 1);
    step(0, 4'h0, 1, 1, 0, 0, 2, 0, 1);
    step(0, 4'h0, 1, 1, 1, 0, 3, 0, 1);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 2);
    step(1, 4'b1011, 0, 0, 0, 1, 0, 0, 0);
    // non-overlapping, same stream
    step(0, 4'h0, 0, 1, 1, 0, 1, 0, 0);
    step(0, 4'h0, 0, 1, 0, 0, 2, 0, 0);
    step(0, 4'h0, 0, 1, 1, 0, 3, 0, 0);
    step(0, 4'h0, 0, 1, 1, 0, 4, 1, 1);
    step(0, 4'h0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 4'h0, 0, 1, 1, 0, 1, 0, 1);
    step(0, 4'h0, 0, 1, 1, 0, 1, 0, 1);
    step(1, 4'b1011, 0, 0, 0, 1, 0, 0, 0);
    // valid gaps; idle bits would change state if consumed
    step(0, 4'h0, 1, 1, 1, 0, 1, 0, 0);
    step(0, 4'h0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 4'h0, 1, 1, 0, 0, 2, 0, 0);
    step(0, 4'h0, 1, 0, 1, 0, 2, 0, 0);
    step(0, 4'h0, 1, 0, 1, 0, 2, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 3, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 1);
    step(0, 4'h0, 1, 0, 1, 0, 4, 1, 1);
    step(0, 4'h0, 1, 0, 1, 0, 4, 1, 1);
    // reach S3, load 0110 (bit discarded), match it, old pattern no longer matches
    step(1, 4'b1011, 1, 0, 0, 1, 0, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 1, 0, 0);
    step(0, 4'h0, 1, 1, 0, 0, 2, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 3, 0, 0);
    step(1, 4'b0110, 1, 1, 1, 0, 0, 0, 0);
    step(0, 4'h0, 1, 1, 0, 0, 1, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 2, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 3, 0, 0);
    step(0, 4'h0, 1, 1, 0, 0, 4, 1, 1);
    step(0, 4'h0, 1, 1, 1, 0, 2, 0, 1);
    step(0, 4'h0, 1, 1, 0, 0, 1, 0, 1);
    step(0, 4'h0, 1, 1, 1, 0, 2, 0, 1);
    step(0, 4'h0, 1, 1, 1, 0, 3, 0, 1);
    // pattern 1111: consecutive matches, saturation, clear with increment
    step(1, 4'b1111, 1, 0, 0, 1, 0, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 1, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 2, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 3, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 1);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 2);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 3);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 3);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 3);
    step(0, 4'h0, 1, 1, 1, 1, 4, 1, 1);
    step(0, 4'h0, 1, 0, 1, 1, 4, 1, 0);
    step(0, 4'h0, 1, 0, 1, 0, 4, 1, 0);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 1);
    // partial progress on 0011, then asynchronous reset restores 1011
    step(1, 4'b0011, 1, 0, 0, 0, 0, 0, 1);
    step(0, 4'h0, 1, 1, 0, 0, 1, 0, 1);
    step(0, 4'h0, 1, 1, 0, 0, 2, 0, 1);
    @(negedge clk);
    reset_n = 0; load = 0; in_valid = 0; cnt_clear = 0;
    #1;
    chk("arst_state", -1, 32'(state_o), 0);
    chk("arst_match", -1, 32'(match), 0);
    chk("arst_cnt", -1, 32'(match_cnt), 0);
    @(negedge clk) reset_n = 1;
    step(0, 4'h0, 1, 1, 1, 0, 1, 0, 0);
    step(0, 4'h0, 1, 1, 0, 0, 2, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 3, 0, 0);
    step(0, 4'h0, 1, 1, 1, 0, 4, 1, 1);
    @(negedge clk) in_valid = 0;
    repeat (2) @(negedge clk);
    chk("drain", -1, 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/moore_pattern_detector.md
# moore_pattern_detector

Parametrised Moore-style serial pattern detector, the generalised successor to the lab's fixed five-state Moore FSM.
- Matches a run-time-programmable PAT_W-bit pattern on a qualified serial bit stream.
- Supports overlapping and non-overlapping match modes.
- Exposes its current state, a registered Moore match flag and an optional saturating match counter.
- Sits between a serial bit source (deserializer, stimulus counter) and lab display or counter logic.

## Interface
- PAT_W, 4: pattern length in bits, 2..16.
- PAT_RST, 4'b1011 (PAT_W bits): pattern register value after reset.
- CNT_W, 8: match counter width.
- ST_W, $clog2(PAT_W+1): state width, derived; not overridden.
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  synchronous pattern load strobe.
- pattern_i  in  PAT_W  new pattern; sampled when load=1.
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping; sampled every cycle.
- in_valid  in  1  qualifies `in`; bit consumed on a clock edge only when in_valid=1.
- in  in  1  serial data bit; first-received bit compares to pattern[PAT_W-1].
- cnt_clear  in  1  synchronous match-counter clear.
- match  out  1  Moore output; 1 exactly when state == PAT_W.
- state_o  out  ST_W  current state = number of pattern prefix bits currently matched.
- match_cnt  out  CNT_W  saturating count of matches.

## Operation
- States S0..S_PAT_W. Sk means the last k accepted bits equal pattern[PAT_W-1 -: k]. S_PAT_W is MATCH.
- Priority per edge is load, then in_valid, then hold.
- load=1:
  - pattern register <= pattern_i.
  - state <= S0 and history <= 0.
  - the bit on `in` is discarded.
- in_valid=0 and load=0: state, history and match hold. MATCH therefore persists across idle cycles.
- in_valid=1, state Sk (k<PAT_W):
  - form candidate string h = last k accepted bits followed by `in`.
  - next state = largest j ≤ k+1 such that the last j bits of h equal the top j pattern bits; j=0 if none.
  - this is a combinational search from j=k+1 down to 1.
- in_valid=1, state MATCH, overlap=1: same rule applied to the full PAT_W-bit history plus `in`, with j ≤ PAT_W.
- in_valid=1, state MATCH, overlap=0: history discarded; next = S1 if in==pattern[PAT_W-1], else S0.
- History is a PAT_W-bit shift register updated on every accepted bit and cleared by load and reset.
- Counter:
  - increments on every edge whose next state is MATCH and whose current state is not MATCH with in_valid=0, so an idle hold does not re-count.
  - saturates at 2^CNT_W-1.
  - cnt_clear=1 sets counter to 0. If an increment coincides with cnt_clear, counter = 1.
- Reset values:
  - state_o=0, match=0, match_cnt=0.
  - pattern register = PAT_RST, history = 0.
- Asserting reset mid-pattern discards partial progress immediately; no output glitch beyond the asynchronous clear.

## Timing
- match and state_o are registered. match rises in the cycle after the edge that accepted the final pattern bit (1-cycle latency).
- match_cnt updates on the same edge on which match rises.
- Back-to-back overlapping matches: with continuous valid bits, match can be high on consecutive cycles only if the pattern is all-equal (e.g. 1111 on input 11111 gives match on cycles 4 and 5).
- The next-state search is purely combinational. PAT_W=16 must close timing at the lab clock with no pipeline stage.

## Configuration
- MOORE_PD_MATCH_CNT_EN defined: counter, saturation and cnt_clear logic are built.
- MOORE_PD_MATCH_CNT_EN undefined: match_cnt tied to 0 and cnt_clear ignored. All other behaviour is identical.

## Structure
- Shared package moore_pd_pkg holds:
  - default PAT_W, CNT_W and PAT_RST constants;
  - a function prefix_len(history, in, pattern, k) returning the next state.
- One sub-module, moore_pd_counter: the saturating counter with clear, instantiated only under MOORE_PD_MATCH_CNT_EN.

## Test plan
- Reset, then idle: reset_n low mid-stream -> state_o=0, match=0, match_cnt=0; pattern reads back as 1011 behaviour.
- Overlap=1, PAT_W=4, pattern 1011, bits 1,0,1,1,0,1,1 all valid -> match high after bits 4 and 7; match_cnt=2.
- Same stream with overlap=0 -> match only after bit 4; final state_o=1; match_cnt=1.
- in_valid gaps inside the pattern (1,gap,0,gap,gap,1,1) -> match after final bit; it stays high through idle cycles with no extra count.
- load of 0110 while in S3 -> state_o=0 the next cycle; then 0,1,1,0 -> match; the old pattern 1011 no longer matches.
- CNT_W=2 with five matches -> match_cnt saturates at 3. cnt_clear coincident with a sixth match -> match_cnt=1.
